sobel_frame_ctrl: RTL and testbench
===================================

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-003 SHALL have port iCLK, input, 1, pixel clock; all state changes on its rising edge.
REQ-004 SHALL have port iRST, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port iDVAL, input, 1, input grayscale pixel valid this cycle.
REQ-006 SHALL have port iSOF, input, 1, qualifies the iDVAL pixel as frame pixel 0.
REQ-007 SHALL have port iFilter, input, 1, requested kernel: 1 = vertical-edge, 0 = horizontal-edge.
REQ-008 SHALL have port oSHIFT, output, 1, line-window shift enable (combinational).
REQ-009 SHALL have port oDVAL, output, 1, filtered output pixel valid (combinational).
REQ-010 SHALL have ports oX, oY, output, 10 each, coordinates of the pixel currently centred in the window.
REQ-011 SHALL have port oEdge, output, 4, {N,S,E,W} border flags for oX/oY.
REQ-012 SHALL have port oFilter, output, 1, kernel select applied to the current frame.
REQ-013 SHALL have ports oBusy and oFrameDone, output, 1 each; oFrameDone is a 1-cycle pulse.
REQ-014 SHALL have port oErr, output, 1, sticky overrun flag (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FILL, RUN, FLUSH; oBusy = (state != IDLE).
REQ-016 In IDLE: oSHIFT=0, oDVAL=0; on iDVAL&&iSOF SHALL accept the pixel (oSHIFT=1 that cycle), set input count to 1, latch iFilter into oFilter, and go to FILL.
REQ-017 In IDLE, iDVAL without iSOF SHALL be ignored (oSHIFT=0).
REQ-018 In FILL: oSHIFT=iDVAL, oDVAL=0; when the accepted-pixel count reaches WIDTH+1, SHALL go to RUN with oX=0, oY=0.
REQ-019 In RUN: oSHIFT=iDVAL, oDVAL=iDVAL; each accepted pixel SHALL advance oX, wrapping WIDTH-1 -> 0 with oY+1.
REQ-020 Output pixel k SHALL be valid in the same cycle as input pixel k+WIDTH+1 is accepted (latency WIDTH+1 accepted pixels).
REQ-021 When the input count reaches WIDTH*HEIGHT, SHALL go to FLUSH on the next edge.
REQ-022 In FLUSH: oSHIFT=1 and oDVAL=1 every cycle regardless of iDVAL, advancing oX/oY, for exactly WIDTH+1 cycles.
REQ-023 On the FLUSH cycle with oX=WIDTH-1, oY=HEIGHT-1, SHALL pulse oFrameDone the following cycle and return to IDLE.
REQ-024 oEdge SHALL be N=(oY==0), S=(oY==HEIGHT-1), E=(oX==WIDTH-1), W=(oX==0), from registered coordinates only.
REQ-025 oFilter SHALL change only on frame-start acceptance; iFilter changes mid-frame SHALL have no effect until the next frame.
REQ-026 iDVAL&&iSOF in FILL or RUN SHALL abort the frame: treat the pixel as a new pixel 0 (count=1, oFilter relatched, FILL), with no oFrameDone.
REQ-027 Input count SHALL be 19 bits unsigned and SHALL never exceed WIDTH*HEIGHT.

Reset
REQ-028 On iRST low: state=IDLE, counts=0, oX=0, oY=0, oFilter=0, oFrameDone=0, oErr=0, oBusy=0, oSHIFT=0, oDVAL=0.
REQ-029 Reset mid-frame SHALL discard the frame; the next frame SHALL require iSOF.

Configuration
REQ-030 With SOBEL_CTRL_OVERRUN_EN defined: iDVAL in FLUSH SHALL set oErr (sticky until reset), and iDVAL&&iSOF in FLUSH SHALL be dropped.
REQ-031 Without SOBEL_CTRL_OVERRUN_EN: oErr SHALL be tied 0 and iDVAL in FLUSH silently ignored.

Verification (WIDTH=8, HEIGHT=4 unless stated)
REQ-032 Continuous iDVAL, iSOF on pixel 0 -> first oDVAL with pixel 9; FLUSH lasts 9 cycles; exactly 32 oDVAL cycles; oFrameDone 1 cycle after (7,3).
REQ-033 iDVAL gaps of 3 cycles every pixel -> oDVAL only with iDVAL in RUN; output count still 32; oX/oY monotonic.
REQ-034 Corners: oEdge=4'b1001 at (0,0), 4'b1010 at (7,0), 4'b0101 at (0,3), 4'b0110 at (7,3).
REQ-035 iFilter toggled at pixel 15 -> oFilter unchanged until next iSOF accepted; iSOF at pixel 20 -> abort, FILL, no oFrameDone.
REQ-036 iRST low during RUN at pixel 20 -> all outputs 0 immediately; iDVAL without iSOF afterwards -> oSHIFT=0.
REQ-037 With SOBEL_CTRL_OVERRUN_EN, iDVAL in FLUSH cycle 2 -> oErr=1 until reset; without it -> oErr stays 0.

Source files
------------

// File: rtl/sobel_frame_ctrl_if.sv
// Pixel-stream handshake and window-control bundle between a pixel source and the Sobel frame controller.
interface sobel_frame_ctrl_if;
    logic       iDVAL;
    logic       iSOF;
    logic       iFilter;
    logic       oSHIFT;
    logic       oDVAL;
    logic [9:0] oX;
    logic [9:0] oY;
    logic [3:0] oEdge;
    logic       oFilter;
    logic       oBusy;
    logic       oFrameDone;
    logic       oErr;

    modport master (
        output iDVAL, iSOF, iFilter,
        input  oSHIFT, oDVAL, oX, oY, oEdge, oFilter, oBusy, oFrameDone, oErr
    );

    modport slave (
        input  iDVAL, iSOF, iFilter,
        output oSHIFT, oDVAL, oX, oY, oEdge, oFilter, oBusy, oFrameDone, oErr
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel line-window: fills WIDTH+1 pixels, streams, then flushes the tail.
// Optional macro SOBEL_CTRL_OVERRUN_EN: flags (sticky oErr) and drops input arriving during FLUSH.
module sobel_frame_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic iCLK,
    input  logic iRST,
    sobel_frame_ctrl_if.slave bus
);
    localparam logic [18:0] FILL_PIX  = 19'(WIDTH + 1);
    localparam logic [18:0] FRAME_PIX = 19'(WIDTH * HEIGHT);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [18:0] cnt;
    logic [9:0]  x_q, y_q;
    logic        filt_q;
    logic        done_q;
    logic        shift, dval;

    // SOF in FLUSH is never a frame start: dropped with the overrun option, ignored without it
    logic sof_hit, x_last, y_last, frame_end;
    assign sof_hit   = bus.iDVAL && bus.iSOF && (state != FLUSH);
    assign x_last    = (x_q == 10'(WIDTH - 1));
    assign y_last    = (y_q == 10'(HEIGHT - 1));
    assign frame_end = (state == FLUSH) && x_last && y_last;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sof_hit) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (bus.iDVAL && cnt == FILL_PIX - 19'd1)  state_nxt = RUN;
                RUN:     if (bus.iDVAL && cnt == FRAME_PIX - 19'd1) state_nxt = FLUSH;
                FLUSH:   if (frame_end)                             state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // An aborting SOF in RUN starts a new frame, so it produces no output pixel
    always_comb begin
        shift = 1'b0;
        dval  = 1'b0;
        case (state)
            IDLE:  shift = sof_hit;
            FILL:  shift = bus.iDVAL;
            RUN: begin
                shift = bus.iDVAL;
                dval  = bus.iDVAL && !bus.iSOF;
            end
            FLUSH: begin
                shift = 1'b1;
                dval  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            filt_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (sof_hit) begin
                cnt    <= 19'd1;
                x_q    <= '0;
                y_q    <= '0;
                filt_q <= bus.iFilter;
            end else begin
                case (state)
                    FILL: if (bus.iDVAL) cnt <= cnt + 19'd1;
                    RUN: if (bus.iDVAL) begin
                        cnt <= cnt + 19'd1;
                        if (x_last) begin
                            x_q <= '0;
                            y_q <= y_q + 10'd1;
                        end else begin
                            x_q <= x_q + 10'd1;
                        end
                    end
                    FLUSH: begin
                        if (frame_end) begin
                            cnt <= '0;
                            x_q <= '0;
                            y_q <= '0;
                        end else if (x_last) begin
                            x_q <= '0;
                            y_q <= y_q + 10'd1;
                        end else begin
                            x_q <= x_q + 10'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SOBEL_CTRL_OVERRUN_EN
    logic err_q;
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST)                                err_q <= 1'b0;
        else if (state == FLUSH && bus.iDVAL)     err_q <= 1'b1;
    end
    assign bus.oErr = err_q;
`else
    assign bus.oErr = 1'b0;
`endif

    assign bus.oSHIFT     = shift;
    assign bus.oDVAL      = dval;
    assign bus.oX         = x_q;
    assign bus.oY         = y_q;
    assign bus.oEdge      = {(y_q == 10'd0), y_last, x_last, (x_q == 10'd0)};
    assign bus.oFilter    = filt_q;
    assign bus.oBusy      = (state != IDLE);
    assign bus.oFrameDone = done_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on an 8x4 frame: latency, flush, gaps, corners, abort, reset, overrun.
module tb_sobel_frame_ctrl;
    localparam int W = 8;
    localparam int H = 4;
`ifdef SOBEL_CTRL_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_frame_ctrl_if bus();
    sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (.iCLK(clk), .iRST(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d, input logic s, input logic f);
        bus.iDVAL   = d;
        bus.iSOF    = s;
        bus.iFilter = f;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // k-th output pixel must sit at raster position k
    task automatic chk_out(input int k);
        chk("out_x", 32'(bus.oX), 32'(k % W));
        chk("out_y", 32'(bus.oY), 32'(k / W));
        case (k)
            0:         chk("edge_00", 32'(bus.oEdge), 32'b1001);
            W - 1:     chk("edge_70", 32'(bus.oEdge), 32'b1010);
            W*(H-1):   chk("edge_03", 32'(bus.oEdge), 32'b0101);
            W*H - 1:   chk("edge_73", 32'(bus.oEdge), 32'b0110);
            default: ;
        endcase
    endtask

    // One full frame with `gap` idle cycles after each pixel; iDVAL pulsed in flush cycle index `ovr`
    task automatic run_frame(input int gap, input logic filt, input int ovr);
        int k = 0;
        int fl = 0;
        bit seen_done = 1'b0;
        for (int p = 0; p < W*H; p++) begin
            for (int g = 0; g <= ((p == W*H-1) ? 0 : gap); g++) begin
                drive(g == 0, (g == 0) && (p == 0), filt);
                #1;
                if (g == 0) chk("dval_run", 32'(bus.oDVAL), 32'(p >= W+1));
                else        chk("dval_gap", 32'(bus.oDVAL), 0);
                chk("shift", 32'(bus.oSHIFT), 32'(g == 0));
                if (bus.oDVAL) begin
                    chk_out(k);
                    k++;
                end
                if (p == 5 && g == 0) chk("busy_mid", 32'(bus.oBusy), 1);
                step();
            end
        end
        for (int j = 0; j < 20; j++) begin
            drive(j == ovr, 1'b0, ~filt);
            #1;
            if (bus.oFrameDone) begin
                seen_done = 1'b1;
                break;
            end
            chk("fl_dval", 32'(bus.oDVAL), 1);
            chk("fl_shift", 32'(bus.oSHIFT), 1);
            chk_out(k);
            k++;
            fl++;
            step();
        end
        chk("frame_done", 32'(seen_done), 1);
        chk("flush_len", 32'(fl), 32'(W+1));
        chk("out_cnt", 32'(k), 32'(W*H));
        chk("busy_end", 32'(bus.oBusy), 0);
        chk("filt_frame", 32'(bus.oFilter), 32'(filt));
        chk("err", 32'(bus.oErr), (ovr >= 0) ? 32'(OVR) : 0);
        drive(0, 0, 0);
        step();
        chk("done_pulse", 32'(bus.oFrameDone), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit seen;
        drive(0, 0, 0);
        #2;
        chk("rst_shift", 32'(bus.oSHIFT), 0);
        chk("rst_dval",  32'(bus.oDVAL), 0);
        chk("rst_busy",  32'(bus.oBusy), 0);
        chk("rst_xy",    32'({bus.oX, bus.oY}), 0);
        chk("rst_filt",  32'(bus.oFilter), 0);
        chk("rst_done",  32'(bus.oFrameDone), 0);
        chk("rst_err",   32'(bus.oErr), 0);
        step();
        rst_n = 1'b1;
        step();

        drive(1, 0, 0);
        #1;
        chk("idle_nosof_shift", 32'(bus.oSHIFT), 0);
        step();
        chk("idle_nosof_busy", 32'(bus.oBusy), 0);

        run_frame(0, 1'b0, -1);
        run_frame(3, 1'b1, -1);
        run_frame(0, 1'b0, 1);

        // abort: iFilter change mid-frame held off, SOF at pixel 20 restarts
        rst_pulse();
        chk("err_cleared", 32'(bus.oErr), 0);
        for (int p = 0; p < 20; p++) begin
            drive(1, p == 0, p >= 15);
            #1;
            if (p >= 15) chk("filt_hold", 32'(bus.oFilter), 0);
            step();
        end
        drive(1, 1, 1);
        #1;
        chk("abort_shift", 32'(bus.oSHIFT), 1);
        chk("abort_filt_pre", 32'(bus.oFilter), 0);
        step();
        chk("abort_filt", 32'(bus.oFilter), 1);
        chk("abort_xy", 32'({bus.oX, bus.oY}), 0);
        chk("abort_busy", 32'(bus.oBusy), 1);
        for (int p = 1; p <= W; p++) begin
            drive(1, 0, 0);
            #1;
            chk("abort_fill", 32'(bus.oDVAL), 0);
            step();
        end
        drive(0, 0, 0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.oFrameDone) seen = 1'b1;
            step();
        end
        chk("abort_nodone", 32'(seen), 0);
        chk("abort_filt_keep", 32'(bus.oFilter), 1);

        // asynchronous reset in RUN
        rst_pulse();
        for (int p = 0; p < 20; p++) begin
            drive(1, p == 0, 1);
            #1;
            step();
        end
        drive(1, 0, 0);
        #1;
        chk("pre_rst_dval", 32'(bus.oDVAL), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_shift", 32'(bus.oSHIFT), 0);
        chk("arst_dval",  32'(bus.oDVAL), 0);
        chk("arst_xy",    32'({bus.oX, bus.oY}), 0);
        chk("arst_filt",  32'(bus.oFilter), 0);
        chk("arst_busy",  32'(bus.oBusy), 0);
        chk("arst_done",  32'(bus.oFrameDone), 0);
        chk("arst_err",   32'(bus.oErr), 0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 0);
        #1;
        chk("post_rst_shift", 32'(bus.oSHIFT), 0);
        step();
        chk("post_rst_busy", 32'(bus.oBusy), 0);
        chk("post_rst_x", 32'(bus.oX), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
